// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual load and auto-scan rotation at a programmable dwell.
// Define MUXSCAN_MASK_EN to add CH_MASK, which makes the scan skip disabled channels.
module mux_scan_sel #(
  parameter int W      = 4,
  parameter int N      = 4,
  parameter int DWELL  = 1000,
  localparam int SW    = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N*W-1:0]  D,
  input  logic            MODE,
  input  logic [SW-1:0]   SEL,
  input  logic            SEL_LD,
  input  logic            HOLD,
`ifdef MUXSCAN_MASK_EN
  input  logic [N-1:0]    CH_MASK,
`endif
  output logic [W-1:0]    DOUT,
  output logic [SW-1:0]   CH,
  output logic            STRB
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {MAN, SCAN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ch_q, ch_d, ch_next;
  logic [W-1:0]  dout_q, dout_d;
  logic          strb_q, strb_d;
  logic [W-1:0]  d_arr [N];
  logic [N-1:0]  ch_mask;
  logic [SW:0]   idx;
  logic          found;

`ifdef MUXSCAN_MASK_EN
  assign ch_mask = CH_MASK;
`else
  assign ch_mask = '1;
`endif

  always_comb begin
    for (int k = 0; k < N; k++) d_arr[k] = D[k*W +: W];
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge values of its peers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= MAN;
      cnt_q   <= '0;
      ch_q    <= '0;
      dout_q  <= '0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      dout_q  <= dout_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d = MODE ? SCAN : MAN;
  end

  // Next enabled index after ch_q, searched cyclically; holds when no other channel is enabled.
  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    ch_next = ch_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i < N; i++) begin
      idx = {1'b0, ch_q} + (SW+1)'(i);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!found && ch_mask[idx[SW-1:0]]) begin
        ch_next = idx[SW-1:0];
        found   = 1'b1;
      end
    end
  end

  // The sampled MODE decides the cycle: a manual cycle or a scan-entry cycle clears the dwell count.
  always_comb begin
    ch_d  = ch_q;
    cnt_d = cnt_q;
    if (!MODE || state_q == MAN) begin
      cnt_d = '0;
      if (!MODE && SEL_LD && ({1'b0, SEL} < (SW+1)'(N))) ch_d = SEL;
    end else if (!HOLD) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        ch_d  = ch_next;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    dout_d = d_arr[ch_d];
    strb_d = (ch_d != ch_q);
  end

  assign DOUT = dout_q;
  assign CH   = ch_q;
  assign STRB = strb_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel: a 4-channel DWELL=3 instance and a 3-channel DWELL=1 instance
// checked against a table, hand-written corner sequences and a behavioural model under random stimulus.
`timescale 1ns/1ps
module tb_mux_scan_sel;
  localparam int W   = 4;
  localparam int N0  = 4;
  localparam int DW0 = 3;
  localparam int N1  = 3;
  localparam int DW1 = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode, sel_ld, hold;
  logic [1:0]      sel;
  logic [N0*W-1:0] d0;
  logic [N1*W-1:0] d1;
  logic [N0-1:0]   mask0;
  logic [N1-1:0]   mask1;
  logic [W-1:0]    dout0, dout1;
  logic [1:0]      ch0, ch1;
  logic            strb0, strb1;

  always #5 clk = ~clk;

  mux_scan_sel #(.W(W), .N(N0), .DWELL(DW0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .D(d0), .MODE(mode), .SEL(sel), .SEL_LD(sel_ld), .HOLD(hold),
`ifdef MUXSCAN_MASK_EN
    .CH_MASK(mask0),
`endif
    .DOUT(dout0), .CH(ch0), .STRB(strb0)
  );

  mux_scan_sel #(.W(W), .N(N1), .DWELL(DW1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .D(d1), .MODE(mode), .SEL(sel), .SEL_LD(sel_ld), .HOLD(hold),
`ifdef MUXSCAN_MASK_EN
    .CH_MASK(mask1),
`endif
    .DOUT(dout1), .CH(ch1), .STRB(strb1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance.
  bit m_scan [2];
  int m_ch   [2];
  int m_cnt  [2];
  int m_dout [2];
  bit m_strb [2];

  typedef struct {
    bit         mode;
    logic [1:0] sel;
    bit         ld;
    bit         hold;
    int         ch;
    bit         strb;
    logic [3:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit md, logic [1:0] s, bit ld, bit hd, int c, bit st, logic [3:0] dv);
    v.mode = md; v.sel = s; v.ld = ld; v.hold = hd; v.ch = c; v.strb = st; v.dout = dv;
  endfunction

  function automatic int next_ch(int c, int n, logic [3:0] msk);
    for (int i = 1; i < n; i++) begin
      if (msk[(c + i) % n]) return (c + i) % n;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scan[k] = 1'b0; m_ch[k] = 0; m_cnt[k] = 0; m_dout[k] = 0; m_strb[k] = 1'b0;
    end
  endtask

  task automatic model_tick(input int k);
    int n, dw, nch;
    logic [15:0] dv;
    logic [3:0]  msk;
    n  = (k == 0) ? N0 : N1;
    dw = (k == 0) ? DW0 : DW1;
    dv = (k == 0) ? d0 : {4'h0, d1};
`ifdef MUXSCAN_MASK_EN
    msk = (k == 0) ? mask0 : {1'b0, mask1};
`else
    msk = 4'hF;
`endif
    nch = m_ch[k];
    if (!mode || !m_scan[k]) begin
      m_cnt[k] = 0;
      if (!mode && sel_ld && int'(sel) < n) nch = int'(sel);
    end else if (!hold) begin
      m_cnt[k] = m_cnt[k] + 1;
      if (m_cnt[k] == dw) begin
        m_cnt[k] = 0;
        nch = next_ch(m_ch[k], n, msk);
      end
    end
    m_scan[k] = mode;
    m_strb[k] = (nch != m_ch[k]);
    m_ch[k]   = nch;
    m_dout[k] = int'((dv >> (nch * W)) & 16'hF);
  endtask

  task automatic check_model();
    check("dout0", 32'(dout0), m_dout[0]);
    check("ch0",   32'(ch0),   m_ch[0]);
    check("strb0", 32'(strb0), 32'(m_strb[0]));
    check("dout1", 32'(dout1), m_dout[1]);
    check("ch1",   32'(ch1),   m_ch[1]);
    check("strb1", 32'(strb1), 32'(m_strb[1]));
  endtask

  // One clock: model sees the same inputs the DUTs sample, outputs compared 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    #1;
    check_model();
  endtask

  task automatic drive(input bit md, input logic [1:0] s, input bit ld, input bit hd);
    mode = md; sel = s; sel_ld = ld; hold = hd;
  endtask

  initial begin
    int cycles;
    int saved;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    d0 = 16'hDCBA;
    d1 = 12'h321;
    mask0 = '1;
    mask1 = '1;
    model_reset();
    #12;
    check("rst_dout0", 32'(dout0), 0);
    check("rst_ch0",   32'(ch0),   0);
    check("rst_strb0", 32'(strb0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual loads, then a full DWELL=3 rotation of dut0 (SEL_LD ignored while MODE=1).
    tbl.push_back(v(0, 2'd2, 1, 0, 2, 1, 4'hC));
    tbl.push_back(v(0, 2'd2, 0, 0, 2, 0, 4'hC));
    tbl.push_back(v(0, 2'd2, 1, 0, 2, 0, 4'hC));
    tbl.push_back(v(0, 2'd3, 1, 0, 3, 1, 4'hD));
    tbl.push_back(v(0, 2'd0, 1, 0, 0, 1, 4'hA));
    tbl.push_back(v(1, 2'd3, 1, 0, 0, 0, 4'hA));
    tbl.push_back(v(1, 2'd3, 1, 0, 0, 0, 4'hA));
    tbl.push_back(v(1, 2'd0, 0, 0, 0, 0, 4'hA));
    tbl.push_back(v(1, 2'd0, 0, 0, 1, 1, 4'hB));
    tbl.push_back(v(1, 2'd0, 0, 0, 1, 0, 4'hB));
    tbl.push_back(v(1, 2'd0, 0, 0, 1, 0, 4'hB));
    tbl.push_back(v(1, 2'd0, 0, 0, 2, 1, 4'hC));
    tbl.push_back(v(1, 2'd0, 0, 0, 2, 0, 4'hC));
    tbl.push_back(v(1, 2'd0, 0, 0, 2, 0, 4'hC));
    tbl.push_back(v(1, 2'd0, 0, 0, 3, 1, 4'hD));
    tbl.push_back(v(1, 2'd0, 0, 0, 3, 0, 4'hD));
    tbl.push_back(v(1, 2'd0, 0, 0, 3, 0, 4'hD));
    tbl.push_back(v(1, 2'd0, 0, 0, 0, 1, 4'hA));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mode, tbl[i].sel, tbl[i].ld, tbl[i].hold);
      step();
      check($sformatf("tbl%0d_ch", i),   32'(ch0),   tbl[i].ch);
      check($sformatf("tbl%0d_strb", i), 32'(strb0), 32'(tbl[i].strb));
      check($sformatf("tbl%0d_dout", i), 32'(dout0), 32'(tbl[i].dout));
    end

    // HOLD at cnt=1 for 5 cycles delays the advance from 2 to 7 cycles.
    drive(1, 2'd0, 0, 0);
    step();
    hold = 1'b1;
    cycles = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cycles++;
      check("hold_strb0", 32'(strb0), 0);
      check("hold_ch0",   32'(ch0),   0);
    end
    hold = 1'b0;
    for (int i = 0; i < 20 && ch0 == 2'd0; i++) begin
      step();
      cycles++;
    end
    check("hold_delay", cycles, 7);
    check("hold_adv_ch0", 32'(ch0), 1);
    check("hold_adv_strb0", 32'(strb0), 1);

    // Leave and re-enter scan at CH=1: the next advance comes DWELL cycles after the entry edge.
    drive(0, 2'd0, 0, 0);
    step();
    check("man_keep_ch0", 32'(ch0), 1);
    mode = 1'b1;
    step();
    cycles = 0;
    for (int i = 0; i < 20 && ch0 == 2'd1; i++) begin
      step();
      cycles++;
    end
    check("reentry_delay", cycles, DW0);
    check("reentry_ch0", 32'(ch0), 2);

    // DWELL=1 instance: CH moves and STRB stays high on every scan cycle.
    for (int i = 0; i < 6; i++) begin
      step();
      check("dwell1_strb1", 32'(strb1), 1);
    end

    // SEL beyond N-1 is ignored by the 3-channel instance.
    drive(0, 2'd0, 0, 0);
    step();
    saved = m_ch[1];
    drive(0, 2'd3, 1, 0);
    step();
    check("sel_oob_ch1", 32'(ch1), saved);
    check("sel_oob_strb1", 32'(strb1), 0);

    // Asynchronous reset mid-scan with CH=2, then a MODE=1 restart must behave as MAN entry.
    drive(0, 2'd2, 1, 0);
    step();
    drive(1, 2'd0, 0, 0);
    step();
    step();
    check("pre_rst_ch0", 32'(ch0), 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_dout0", 32'(dout0), 0);
    check("arst_ch0",   32'(ch0),   0);
    check("arst_strb0", 32'(strb0), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    for (int i = 0; i < 20 && ch0 == 2'd0; i++) begin
      step();
      cycles++;
    end
    check("post_rst_first_adv", cycles, DW0 + 1);

`ifdef MUXSCAN_MASK_EN
    // Masked scan visits only enabled channels; an empty mask freezes CH.
    mask0 = 4'b1010;
    drive(0, 2'd1, 1, 0);
    step();
    drive(1, 2'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      saved = int'(ch0);
      for (int i = 0; i < 20 && int'(ch0) == saved; i++) step();
      check("mask_seq_ch0", 32'(ch0), (k % 2 == 0) ? 3 : 1);
    end
    mask0 = 4'b0000;
    saved = int'(ch0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("mask0_ch0", 32'(ch0), saved);
      check("mask0_strb0", 32'(strb0), 0);
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel    = 2'($urandom_range(0, 3));
      sel_ld = ($urandom_range(0, 3) == 0);
      hold   = ($urandom_range(0, 7) == 0);
      d0     = 16'($urandom);
      d1     = 12'($urandom);
`ifdef MUXSCAN_MASK_EN
      mask0  = 4'($urandom);
      mask1  = 3'($urandom);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
